// File: rtl/prio_arbiter.sv
// Priority arbiter with fixed / round-robin selection, grant holding and a per-grant
// hold limit that temporarily masks a requester after a forced release.
module prio_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic          LIMIT_ON = (MAX_HOLD > 0);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] last_r;
  logic [CW-1:0] hold_cnt_r;
  logic          mask_valid_r;
  logic [IW-1:0] mask_idx_r;

  logic          hold_s;
  logic          limit_s;
  logic          keep_s;
  logic          force_s;
  logic          mask_valid_n;
  logic [IW-1:0] mask_idx_n;
  logic [N-1:0]  mask_vec_s;
  logic [N-1:0]  elig_s;
  logic          win_found_s;
  logic [IW-1:0] win_idx_s;

  // Hold / forced-release decision and next mask; a forced release masks the holder
  // in the same cycle so it cannot win the arbitration that replaces it.
  always_comb begin
    hold_s  = gnt_valid & req[gnt_idx];
    limit_s = LIMIT_ON & (hold_cnt_r == MAX_C);
    keep_s  = hold_s & ~limit_s;
    force_s = hold_s & limit_s;
    if (force_s) begin
      mask_valid_n = 1'b1;
      mask_idx_n   = gnt_idx;
    end else if (mask_valid_r && !req[mask_idx_r]) begin
      mask_valid_n = 1'b0;
      mask_idx_n   = {IW{1'b0}};
    end else begin
      mask_valid_n = mask_valid_r;
      mask_idx_n   = mask_idx_r;
    end
    mask_vec_s = mask_valid_n ? (ONE << mask_idx_n) : {N{1'b0}};
    elig_s     = req & ~mask_vec_s;
  end

  // Downward search: fixed starts at N-1, round-robin starts just below last.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      logic [IW-1:0] pos;
      if (mode) begin
        pos = IW'((int'(last_r) + N - k) % N);
      end else begin
        pos = IW'(N - k);
      end
      if (!win_found_s && elig_s[pos]) begin
        win_found_s = 1'b1;
        win_idx_s   = pos;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant, history, hold counter and mask registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt          <= {N{1'b0}};
      gnt_valid    <= 1'b0;
      gnt_idx      <= {IW{1'b0}};
      last_r       <= {IW{1'b0}};
      hold_cnt_r   <= {CW{1'b0}};
      mask_valid_r <= 1'b0;
      mask_idx_r   <= {IW{1'b0}};
    end else begin
      mask_valid_r <= mask_valid_n;
      mask_idx_r   <= mask_idx_n;
      if (keep_s) begin
        hold_cnt_r <= (hold_cnt_r == {CW{1'b1}}) ? hold_cnt_r : hold_cnt_r + CNT_ONE;
      end else if (win_found_s) begin
        gnt        <= ONE << win_idx_s;
        gnt_valid  <= 1'b1;
        gnt_idx    <= win_idx_s;
        last_r     <= win_idx_s;
        hold_cnt_r <= CNT_ONE;
      end else begin
        gnt        <= {N{1'b0}};
        gnt_valid  <= 1'b0;
        gnt_idx    <= {IW{1'b0}};
        hold_cnt_r <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=8, MAX_HOLD=4): each step queues the expected
// grant for the next edge and checks it after that edge.
module tb_prio_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  prio_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] r, input logic m, input logic v,
                      input logic [2:0] idx, input string tag);
    exp_t       e;
    exp_t       o;
    logic [7:0] eg;
    req   = r;
    mode  = m;
    e.v   = v;
    e.idx = v ? idx : 3'd0;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o  = sb.pop_front();
    eg = o.v ? (8'd1 << o.idx) : 8'd0;
    checks++;
    assert (gnt === eg) else begin
      fails++;
      $error("FAIL %s gnt: observed %b expected %b", o.tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === o.v) else begin
      fails++;
      $error("FAIL %s gnt_valid: observed %b expected %b", o.tag, gnt_valid, o.v);
    end
    checks++;
    assert (gnt_idx === o.idx) else begin
      fails++;
      $error("FAIL %s gnt_idx: observed %0d expected %0d", o.tag, gnt_idx, o.idx);
    end
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0;
    req   = 8'h00;
    mode  = 1'b0;
    step(8'hFF, 1'b0, 1'b0, 3'd0, "reset");
    step(8'hFF, 1'b1, 1'b0, 3'd0, "reset2");
    rst_n = 1'b1;
    step(8'h00, 1'b0, 1'b0, 3'd0, "idle");

    // Fixed priority, held to the limit, then back-to-back handover to 2.
    for (int i = 0; i < 4; i++) step(8'h26, 1'b0, 1'b1, 3'd5, "fix_hold");
    step(8'h26, 1'b0, 1'b1, 3'd2, "fix_limit_handover");
    step(8'h00, 1'b0, 1'b0, 3'd0, "fix_idle");

    // Round-robin from reset: 7,6,...,0,7 with each holder dropping for one cycle.
    rst_n = 1'b0;
    step(8'hFF, 1'b1, 1'b0, 3'd0, "rr_reset");
    rst_n = 1'b1;
    step(8'hFF, 1'b1, 1'b1, 3'd7, "rr_first");
    for (int i = 7; i >= 0; i--) begin
      r = 8'hFF & ~(8'd1 << i);
      step(r, 1'b1, 1'b1, 3'((i + 7) % 8), "rr_seq");
    end
    step(8'h00, 1'b1, 1'b0, 3'd0, "rr_idle");

    // Hold limit with two requesters; req[3] toggles low while 0 is held.
    for (int i = 0; i < 4; i++) step(8'h09, 1'b0, 1'b1, 3'd3, "lim_3");
    step(8'h09, 1'b0, 1'b1, 3'd0, "lim_0a");
    step(8'h09, 1'b0, 1'b1, 3'd0, "lim_0b");
    step(8'h01, 1'b0, 1'b1, 3'd0, "lim_0c");
    step(8'h09, 1'b0, 1'b1, 3'd0, "lim_0d");
    step(8'h09, 1'b0, 1'b1, 3'd3, "lim_3_again");
    step(8'h00, 1'b0, 1'b0, 3'd0, "lim_idle");

    // Single requester: masked after the limit until it drops req.
    for (int i = 0; i < 4; i++) step(8'h04, 1'b0, 1'b1, 3'd2, "single_hold");
    step(8'h04, 1'b0, 1'b0, 3'd0, "single_masked1");
    step(8'h04, 1'b0, 1'b0, 3'd0, "single_masked2");
    step(8'h00, 1'b0, 1'b0, 3'd0, "single_drop");
    step(8'h04, 1'b0, 1'b1, 3'd2, "single_regrant");

    // Reset mid-grant; last returns to 0 so round-robin starts at 7.
    step(8'h40, 1'b0, 1'b1, 3'd6, "pre_reset_6");
    rst_n = 1'b0;
    step(8'h40, 1'b0, 1'b0, 3'd0, "reset_mid");
    rst_n = 1'b1;
    step(8'h42, 1'b1, 1'b1, 3'd6, "post_reset_rr");

    // Mode toggle while 2 is held: grant unchanged, next winner uses fixed mode.
    step(8'h04, 1'b1, 1'b1, 3'd2, "toggle_grant2");
    step(8'h0C, 1'b0, 1'b1, 3'd2, "toggle_held");
    step(8'h0A, 1'b0, 1'b1, 3'd3, "toggle_next_fixed");
    step(8'h00, 1'b0, 1'b0, 3'd0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
